// File: rtl/float_params.sv
// Shared definitions for the float add/subtract pipeline.
// Holds the default IEEE-754 single-precision field layout, the packed float
// struct, canonical special-value constants, and real<->float helpers used by
// benches (the helpers assume the default 32-bit layout).
package float_params;

    localparam int FLOAT_WIDTH = 32;
    localparam int EXP_WIDTH   = 8;
    localparam int MANT_WIDTH  = 23;
    localparam int TAG_WIDTH   = 4;
    localparam int EXP_BIAS    = 127;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] mant;
    } float_t;

    localparam logic [FLOAT_WIDTH-1:0] FLOAT_QNAN = 32'h7FC0_0000;
    localparam logic [FLOAT_WIDTH-1:0] FLOAT_PINF = 32'h7F80_0000;
    localparam logic [FLOAT_WIDTH-1:0] FLOAT_NINF = 32'hFF80_0000;

    // real -> float, truncating the mantissa; tiny values flush to zero.
    function automatic float_t make_float(input real r);
        logic [63:0] d;
        int          e;
        float_t      f;
        d      = $realtobits(r);
        e      = int'(d[62:52]) - 1023 + EXP_BIAS;
        f.sign = d[63];
        if (d[62:52] == '0 || e <= 0) begin
            f.exp  = '0;
            f.mant = '0;
        end else if (e >= (1 << EXP_WIDTH) - 1) begin
            f.exp  = '1;
            f.mant = '0;
        end else begin
            f.exp  = EXP_WIDTH'(e);
            f.mant = d[51 -: MANT_WIDTH];
        end
        return f;
    endfunction

    // float -> real; zero exponent reads as signed zero.
    function automatic real to_real(input float_t f);
        logic [63:0] d;
        logic [10:0] e11;
        if (f.exp == '0)      e11 = '0;
        else if (f.exp == '1) e11 = '1;
        else                  e11 = 11'(int'(f.exp) - EXP_BIAS + 1023);
        d = {f.sign, e11, f.mant, 29'b0};
        if (f.exp == '0) d[51:0] = '0;
        return $bitstoreal(d);
    endfunction

    function automatic bit reals_near(input real x, input real y, input real rel_tol);
        real diff;
        real mag;
        diff = (x > y) ? x - y : y - x;
        mag  = (x < 0.0) ? -x : x;
        if (((y < 0.0) ? -y : y) > mag) mag = (y < 0.0) ? -y : y;
        return diff <= rel_tol * mag + 1.0e-30;
    endfunction

endpackage

// File: rtl/float_addsub_pipeline_if.sv
// Request/result bundle of the float add/subtract pipeline.
//   req/sub/a/b/tag_in : one operation per cycle from the issue side
//   ack/out/tag_out    : result, valid for one cycle per accepted req
// master = issue/writeback side, slave = the pipeline.
interface float_addsub_pipeline_if
    import float_params::*;
#(
    parameter int FLOAT_WIDTH = float_params::FLOAT_WIDTH,
    parameter int TAG_WIDTH   = float_params::TAG_WIDTH
);
    logic                   req;
    logic                   sub;
    logic [FLOAT_WIDTH-1:0] a;
    logic [FLOAT_WIDTH-1:0] b;
    logic [TAG_WIDTH-1:0]   tag_in;
    logic                   ack;
    logic [FLOAT_WIDTH-1:0] out;
    logic [TAG_WIDTH-1:0]   tag_out;

    modport master (output req, sub, a, b, tag_in, input  ack, out, tag_out);
    modport slave  (input  req, sub, a, b, tag_in, output ack, out, tag_out);
endinterface

// File: rtl/float_lzc.sv
// Combinational leading-zero counter.
//   value : vector to scan from the MSB
//   count : number of zeros above the highest set bit (WIDTH when value==0)
module float_lzc #(
    parameter int WIDTH = 26,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);
    // Scan upward so the highest set bit writes last.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/float_addsub_pipeline.sv
// Fully pipelined floating-point adder/subtractor, one op per cycle, latency 4.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of float_addsub_pipeline_if (req/sub/a/b/tag_in in,
//              ack/out/tag_out out). out/tag_out hold between acks.
// Truncating rounding, denormals flushed to zero, specials bypass the datapath.
module float_addsub_pipeline
    import float_params::*;
#(
    parameter int FLOAT_WIDTH = float_params::FLOAT_WIDTH,
    parameter int EXP_WIDTH   = float_params::EXP_WIDTH,
    parameter int MANT_WIDTH  = float_params::MANT_WIDTH,
    parameter int TAG_WIDTH   = float_params::TAG_WIDTH
) (
    input logic                     clk,
    input logic                     rst,
    float_addsub_pipeline_if.slave  bus
);
    localparam int E  = EXP_WIDTH;
    localparam int M  = MANT_WIDTH;
    localparam int SW = M + 3;              // hidden bit + mantissa + 2 guard bits
    localparam int XW = E + 2;              // signed exponent with under/overflow room
    localparam int CW = $clog2(SW + 1);
    localparam logic [E-1:0] EXP_ONES = '1;
    localparam logic [FLOAT_WIDTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    function automatic logic [FLOAT_WIDTH-1:0] pack_result(
        input logic                 sign,
        input logic signed [XW-1:0] e_in,
        input logic [M-1:0]         mant,
        input logic                 zero
    );
        logic [FLOAT_WIDTH-1:0] res;
        if (zero)                                  res = '0;
        else if (e_in[XW-1] || e_in == '0)         res = {sign, {(FLOAT_WIDTH-1){1'b0}}};
        else if (e_in[XW-2:0] >= {1'b0, EXP_ONES}) res = {sign, EXP_ONES, {M{1'b0}}};
        else                                       res = {sign, e_in[E-1:0], mant};
        return res;
    endfunction

    // ---- stage 0: input capture ----
    logic                   vld_p0, sub_p0;
    logic [FLOAT_WIDTH-1:0] a_p0, b_p0;
    logic [TAG_WIDTH-1:0]   tag_p0;

    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= bus.req;
        sub_p0 <= bus.sub;
        a_p0   <= bus.a;
        b_p0   <= bus.b;
        tag_p0 <= bus.tag_in;
    end

    // ---- stage 1: decode, special detection, swap and align ----
    logic                   sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [E-1:0]           ea, eb, diff;
    logic [M-1:0]           ma, mb;
    logic [SW-1:0]          sig_s_raw;
    logic                   byp;
    logic [FLOAT_WIDTH-1:0] byp_val;

    assign {sa, ea, ma} = a_p0;
    assign sb           = b_p0[FLOAT_WIDTH-1] ^ sub_p0;
    assign {eb, mb}     = b_p0[FLOAT_WIDTH-2:0];
    assign a_zero       = (ea == '0);
    assign b_zero       = (eb == '0);
    assign a_nan        = (ea == EXP_ONES) && (ma != '0);
    assign b_nan        = (eb == EXP_ONES) && (mb != '0);
    assign a_inf        = (ea == EXP_ONES) && (ma == '0);
    assign b_inf        = (eb == EXP_ONES) && (mb == '0);
    assign a_big        = ({ea, ma} >= {eb, mb});
    assign diff         = a_big ? ea - eb : eb - ea;
    assign sig_s_raw    = {1'b1, (a_big ? mb : ma), 2'b00};

    // Specials and zero operands produce their result here and skip the datapath.
    always_comb begin
        byp     = 1'b1;
        byp_val = '0;
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) byp_val = QNAN;
        else if (a_inf)             byp_val = {sa, ea, ma};
        else if (b_inf)             byp_val = {sb, eb, mb};
        else if (a_zero && b_zero)  byp_val = {sa & sb, {(FLOAT_WIDTH-1){1'b0}}};
        else if (a_zero)            byp_val = {sb, eb, mb};
        else if (b_zero)            byp_val = {sa, ea, ma};
        else                        byp     = 1'b0;
    end

    logic                   vld_p1, sign_p1, eff_sub_p1, byp_p1;
    logic [E-1:0]           exp_p1;
    logic [SW-1:0]          sig_l_p1, sig_s_p1;
    logic [FLOAT_WIDTH-1:0] byp_val_p1;
    logic [TAG_WIDTH-1:0]   tag_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
        sign_p1    <= a_big ? sa : sb;
        eff_sub_p1 <= sa ^ sb;
        exp_p1     <= a_big ? ea : eb;
        sig_l_p1   <= {1'b1, (a_big ? ma : mb), 2'b00};
        sig_s_p1   <= (diff >= E'(SW)) ? '0 : sig_s_raw >> diff;
        byp_p1     <= byp;
        byp_val_p1 <= byp_val;
        tag_p1     <= tag_p0;
    end

    // ---- stage 2: magnitude add/subtract (larger minus smaller never goes negative) ----
    logic                   vld_p2, sign_p2, byp_p2;
    logic [E-1:0]           exp_p2;
    logic [SW:0]            sum_p2;
    logic [FLOAT_WIDTH-1:0] byp_val_p2;
    logic [TAG_WIDTH-1:0]   tag_p2;

    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
        sign_p2    <= sign_p1;
        exp_p2     <= exp_p1;
        sum_p2     <= eff_sub_p1 ? {1'b0, sig_l_p1} - {1'b0, sig_s_p1}
                                 : {1'b0, sig_l_p1} + {1'b0, sig_s_p1};
        byp_p2     <= byp_p1;
        byp_val_p2 <= byp_val_p1;
        tag_p2     <= tag_p1;
    end

    // ---- stage 3: normalise so the leading one sits at bit SW-1 ----
    logic [CW-1:0]          lz;
    logic [SW:0]            norm;
    logic signed [XW-1:0]   exp_x, exp_n;

    float_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (.value(sum_p2[SW-1:0]), .count(lz));

    assign exp_x = $signed({2'b00, exp_p2});

    always_comb begin
        if (sum_p2[SW]) begin
            norm  = sum_p2 >> 1;
            exp_n = exp_x + $signed(XW'(1));
        end else begin
            norm  = sum_p2 << lz;
            exp_n = exp_x - $signed(XW'(lz));
        end
    end

    logic                   vld_p3, sign_p3, zero_p3, byp_p3;
    logic signed [XW-1:0]   exp_p3;
    logic [M-1:0]           mant_p3;
    logic [FLOAT_WIDTH-1:0] byp_val_p3;
    logic [TAG_WIDTH-1:0]   tag_p3;

    always_ff @(posedge clk) begin
        if (rst) vld_p3 <= 1'b0;
        else     vld_p3 <= vld_p2;
        sign_p3    <= sign_p2;
        zero_p3    <= (sum_p2 == '0);
        exp_p3     <= exp_n;
        mant_p3    <= M'(norm >> 2);    // drops guard bits (truncation) and the hidden bit
        byp_p3     <= byp_p2;
        byp_val_p3 <= byp_val_p2;
        tag_p3     <= tag_p2;
    end

    // ---- stage 4: pack and present; result holds until the next ack ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack     <= 1'b0;
            bus.out     <= '0;
            bus.tag_out <= '0;
        end else begin
            bus.ack <= vld_p3;
            if (vld_p3) begin
                bus.out     <= byp_p3 ? byp_val_p3 : pack_result(sign_p3, exp_p3, mant_p3, zero_p3);
                bus.tag_out <= tag_p3;
            end
        end
    end
endmodule

// File: doc/float_addsub_pipeline.md
Name: float_addsub_pipeline

Overview:
Fully pipelined floating-point adder/subtractor. It is the parametrised successor to the single-operation float adder: it accepts one operation per cycle, has a per-request add/subtract mode, carries a tag alongside each operation, and handles zero, overflow and infinity explicitly. It sits between the GPU core's float issue logic and its writeback path. Operand and result format is IEEE-754 layout (sign, biased exponent, mantissa with hidden bit).

Parameters:
FLOAT_WIDTH, 32, total operand/result width
EXP_WIDTH, 8, exponent field width
MANT_WIDTH, 23, stored mantissa width (hidden bit excluded); FLOAT_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
TAG_WIDTH, 4, width of the opaque tag passed through with each request

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req  input  1  operation valid this cycle; no backpressure, accepted every cycle
sub  input  1  0: out = a + b; 1: out = a - b (b sign inverted at input)
a  input  FLOAT_WIDTH  operand a
b  input  FLOAT_WIDTH  operand b
tag_in  input  TAG_WIDTH  tag captured with req
ack  output  1  result valid, exactly one cycle per accepted req
out  output  FLOAT_WIDTH  result, valid when ack=1
tag_out  output  TAG_WIDTH  tag_in of the request whose result is on out

Behaviour:
- Reset: rst=1 at a posedge clears every stage valid bit; ack=0, out=0, tag_out=0 at the next posedge. In-flight operations are discarded and never acked. req is ignored while rst=1.
- Latency fixed at 4: req sampled high at posedge N -> ack=1 with result after posedge N+4 (visible during cycle N+4 to N+5); ack low again after N+5 unless a later req is due.
- Throughput 1/cycle; back-to-back reqs produce back-to-back acks, order preserved. ack mirrors the req pattern delayed by 4.
- out and tag_out hold their last value when ack=0. They are not cleared except by reset.
- Stage 1 (align): decode fields, prepend hidden bit (exp==0 -> operand is zero, denormals flushed). Swap so the larger magnitude is first. Right-shift the smaller mantissa by the exponent difference; a shift >= MANT_WIDTH+3 gives 0. Keep 2 guard bits, truncated.
- Stage 2 (add): same effective sign -> add magnitudes; otherwise subtract smaller from larger. Result sign = sign of the larger magnitude.
- Stage 3 (normalise): a carry-out shifts right 1 and increments the exponent. Otherwise a leading-zero count gives a left shift, and the exponent is decremented by it.
- Stage 4 (pack): truncation rounding (toward zero).
  - Zero magnitude gives +0 (exact cancellation such as 1.5-1.5 is +0).
  - Exponent <= 0 flushes to signed zero.
  - Exponent >= all-ones gives signed infinity.
- Special inputs (exp all-ones):
  - inf op finite -> that inf.
  - inf + inf of the same sign -> that inf.
  - Opposite-sign infs -> canonical NaN (exp all-ones, mantissa MSB=1, sign 0).
  - Any NaN input -> canonical NaN.
  - These flags ride the pipeline; latency is unchanged.
- One operand zero -> result equals the other operand exactly (sign of b applied after sub). 0 + 0 = +0; -0 + -0 = -0.

Decomposition:
- Shared package float_params: FLOAT_WIDTH/EXP_WIDTH/MANT_WIDTH defaults, EXP_BIAS=127, a packed float_t struct (sign/exp/mant), canonical NaN/inf constants, and bench helpers make_float / to_real / reals_near.
- One sub-module: float_lzc (parametrised combinational leading-zero counter, used in stage 3).

Test Plan:
- Reset then idle: rst high 2 cycles -> ack=0, out=0, tag_out=0; no ack for 10 cycles with req=0.
- Single add: a=1.23, b=2.56, sub=0, tag=3 at cycle N -> ack only at N+4, out≈3.79, tag_out=3; ack=0 at N+5.
- Back-to-back, mixed mode: consecutive cycles (2.0+3.0, t1), (2000.0-300.0, t2), (-5.1+-3.2, t3), (1.25-1.5, t4) -> four consecutive acks with 5.0, 1700.0, -8.3, -0.25 and tags 1..4 in order.
- Cancellation and zero: 1.5-1.5 -> +0 (0x00000000); 0.0+-7.0 -> -7.0 exactly; 0.000123+0.000000456 -> ≈0.000123456.
- Specials: max-finite + max-finite -> +inf (0x7F800000); +inf - +inf -> 0x7FC00000; NaN+1.0 -> 0x7FC00000; each with latency 4.
- Reset mid-flight: reqs at N and N+1, rst=1 at N+2 for one cycle -> no ack ever for them. A req at N+4 acks at N+8 with the correct result.
